// File: rtl/adex_spike_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : adex_spike_encoder_if
//  Description : Event stream from the AdEx spike encoder.
//                The encoder drives the FIFO head. The consumer drives ready.
//                Build option SPIKE_ISI_EN adds the evt_isi field.
//  Revision    : 1.0  initial release
// ============================================================================
interface adex_spike_encoder_if #(
    parameter int TS_W = 16
);
    logic                evt_valid;
    logic                evt_ready;
    logic [TS_W-1:0]     evt_ts;
    logic signed [15:0]  evt_u;
`ifdef SPIKE_ISI_EN
    logic [TS_W-1:0]     evt_isi;

    modport master (output evt_valid, output evt_ts, output evt_u,
                    output evt_isi, input evt_ready);
    modport slave  (input evt_valid, input evt_ts, input evt_u,
                    input evt_isi, output evt_ready);
`else
    modport master (output evt_valid, output evt_ts, output evt_u,
                    input evt_ready);
    modport slave  (input evt_valid, input evt_ts, input evt_u,
                    output evt_ready);
`endif
endinterface
`default_nettype wire

// File: rtl/adex_spike_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : adex_spike_encoder
//  Description : Detects rising threshold crossings of the AdEx membrane
//                potential. Each crossing is queued as an event {ts, u} in a
//                circular FIFO. The FIFO is drained over valid/ready.
//                Build option SPIKE_ISI_EN adds an inter-spike interval
//                field (evt_isi) to each event.
//  Revision    : 1.0  initial release
// ============================================================================
module adex_spike_encoder #(
    parameter logic signed [15:0] V_T   = 16'sd30,
    parameter int                 TS_W  = 16,
    parameter int                 DEPTH = 8
) (
    input  wire logic                      clk,
    input  wire logic                      reset_n,
    input  wire logic                      en_i,
    input  wire logic signed [15:0]        v_i,
    input  wire logic signed [15:0]        u_i,
    adex_spike_encoder_if.master           evt,
    output logic                           spike_o,
    output logic [$clog2(DEPTH):0]         fifo_count_o,
    output logic                           overflow_o,
    output logic [15:0]                    drop_cnt_o
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
`ifdef SPIKE_ISI_EN
    localparam int c_EW = TS_W + TS_W + 16;
`else
    localparam int c_EW = TS_W + 16;
`endif

    logic [TS_W-1:0]  ts_q;
    logic             above_q;
    logic             spike_q;
    logic             overflow_q;
    logic [15:0]      drop_cnt_q;
    logic [15:0]      drop_cnt_d;
    logic [c_AW-1:0]  wr_ptr_q;
    logic [c_AW-1:0]  rd_ptr_q;
    logic [c_CW-1:0]  count_q;
    logic [c_CW-1:0]  count_d;
    logic [c_EW-1:0]  mem_q [DEPTH];
    logic [c_EW-1:0]  entry_d;
    logic [c_EW-1:0]  head_w;

    logic above_w;
    logic det_w;
    logic pop_w;
    logic full_w;
    logic push_w;
    logic drop_w;

    assign above_w = (v_i >= V_T);
    assign det_w   = en_i & above_w & ~above_q;
    assign pop_w   = (count_q != '0) & evt.evt_ready;
    assign full_w  = (count_q == c_CW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_w  = det_w & (~full_w | pop_w);
    assign drop_w  = det_w & full_w & ~pop_w;

`ifdef SPIKE_ISI_EN
    logic [TS_W-1:0] last_ts_q;
    logic            first_q;
    logic [TS_W-1:0] isi_w;

    // The first spike after reset has no predecessor, so it reports all ones.
    assign isi_w   = first_q ? {TS_W{1'b1}} : (ts_q - last_ts_q);
    assign entry_d = {isi_w, ts_q, u_i};

    // Remember the time of every detected spike, including dropped ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_ts_q <= '0;
            first_q   <= 1'b1;
        end else if (det_w) begin
            last_ts_q <= ts_q;
            first_q   <= 1'b0;
        end
    end

    assign evt.evt_isi = head_w[c_EW-1 -: TS_W];
`else
    assign entry_d = {ts_q, u_i};
`endif

    // Occupancy next-state: simultaneous push and pop leave the count alone.
    always_comb begin
        count_d = count_q;
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Saturating counter of events lost to a full FIFO.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_w && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Free-running timestamp, edge-detect history and spike pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q    <= '0;
            above_q <= 1'b0;
            spike_q <= 1'b0;
        end else begin
            ts_q    <= ts_q + 1'b1;
            above_q <= above_w;
            spike_q <= det_w;
        end
    end

    // Circular event buffer with wrapping pointers and sticky drop status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (push_w) begin
                mem_q[wr_ptr_q] <= entry_d;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            if (drop_w) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign head_w        = mem_q[rd_ptr_q];
    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_ts    = head_w[TS_W+15:16];
    assign evt.evt_u     = head_w[15:0];
    assign spike_o       = spike_q;
    assign fifo_count_o  = count_q;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule
`default_nettype wire
